// File: rtl/sce_pipe_pkg.sv
// rtl/sce_pipe_pkg.sv - shared defaults and width helpers for the wave capture pipeline
package sce_pipe_pkg;

  localparam int DEF_NI         = 5;
  localparam int DEF_NO         = 2;
  localparam int DEF_DEPTH      = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  // Pointer width for an n-entry ring; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold every value 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sce_result_fifo.sv
// rtl/sce_result_fifo.sv - synchronous result FIFO with occupancy count and simultaneous push/pop
module sce_result_fifo
  import sce_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_NO,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a full FIFO still takes a push then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Explicit wrap keeps the ring correct even if DEPTH were not a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Head entry when occupied, zero otherwise so the output is defined after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - drives a path-balanced netlist and captures its results under credit flow control
module wave_capture
  import sce_pipe_pkg::*;
#(
  parameter int NI         = DEF_NI,
  parameter int NO         = DEF_NO,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NI-1:0]                    in_data,
  output logic [NI-1:0]                    net_x,
  input  logic [NO-1:0]                    net_y,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NO-1:0]                    out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight
);

  localparam int CW = count_width(FIFO_DEPTH);

  logic [DEPTH-1:0] tag;
  logic             accept;
  logic             capture;
  logic             pop;
  logic             fifo_empty;
  logic             alive;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      outstanding;

  // The netlist cannot stall, so a vector is only launched when a FIFO slot is
  // already reserved for its result: buffered plus in-flight must stay below depth.
  assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready    = alive & (outstanding < (CW + 1)'(FIFO_DEPTH));

  assign accept    = in_valid & in_ready;
  assign capture   = tag[DEPTH-1];
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Holds in_ready low through reset and releases it on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Launch register feeding the netlist inputs; changes only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_x <= '0;
    end else if (accept) begin
      net_x <= in_data;
    end
  end

  // Tag delay line marks the edge at which each launched vector reaches net_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag <= (tag << 1) | DEPTH'(accept);
    end
  end

  // Vectors launched but whose result has not yet been written into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(capture);
    end
  end

  sce_result_fifo #(
    .WIDTH (NO),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (net_y),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - scoreboard bench for wave_capture driving a pipelined c17 netlist
module tb_wave_capture;

  localparam int NI = 5;
  localparam int NO = 2;
  localparam int DEPTH = 5;
  localparam int FIFO_DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] in_data;
  logic [NI-1:0] net_x;
  logic [NO-1:0] net_y;
  logic          out_valid;
  logic          out_ready;
  logic [NO-1:0] out_data;
  logic [2:0]    inflight;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic settled;

  typedef struct {
    logic [NO-1:0] data;
    int            edge_no;
  } exp_t;
  exp_t q[$];

  wave_capture #(
    .NI(NI), .NO(NO), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .net_x(net_x), .net_y(net_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .inflight(inflight)
  );

  function automatic logic [1:0] c17(input logic [4:0] x);
    logic y0, y1;
    y0 = (x[0] & x[2]) | (x[1] & ~(x[2] & x[3]));
    y1 = ~(x[2] & x[3]) & (x[1] | x[4]);
    return {y1, y0};
  endfunction

  // Netlist stand-in: c17 on the launch register followed by DEPTH-1 balancing registers.
  logic [NO-1:0] pipe [DEPTH-1];
  always @(posedge clk) begin
    pipe[0] <= c17(net_x);
    for (int i = 1; i < DEPTH - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign net_y = pipe[DEPTH-2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) settled <= 1'b0;
    else        settled <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each vector's expected result and launch edge; a result is due
  // DEPTH edges after launch and leaves the queue when downstream takes it.
  always @(negedge clk) begin
    int  n_in;
    int  n_buf;
    bit  exp_valid;
    bit  exp_ready;
    if (!rst_n) begin
      q.delete();
    end else begin
      n_in = 0;
      n_buf = 0;
      foreach (q[i]) begin
        if (q[i].edge_no + DEPTH <= cyc) n_buf++;
        else n_in++;
      end
      exp_valid = (q.size() > 0) && (q[0].edge_no + DEPTH <= cyc);
      exp_ready = settled && (q.size() < FIFO_DEPTH);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_valid);
      check("inflight", inflight, n_in);
      check("fifo_count", dut.u_fifo.count, n_buf);
      if (!exp_valid) check("out_data_idle", out_data, 0);
      if (exp_valid && out_ready) begin
        check("out_data", out_data, q[0].data);
        void'(q.pop_front());
      end
      if (in_valid && exp_ready) q.push_back('{data: c17(in_data), edge_no: cyc + 1});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [NI-1:0] v);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 1, 0);
    step();
  endtask

  initial begin
    int j;
    int acc;
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_inflight", inflight, 0);
    check("rst_net_x", net_x, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold_ready", in_ready, 0);
    repeat (2) step();

    // single-vector latency
    in_valid = 1'b1; in_data = 5'b00101;
    step();
    in_valid = 1'b0;
    j = 0;
    @(negedge clk);
    while (!out_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("latency", j, DEPTH);
    check("single_data", out_data, 2'b01);
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;

    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(NI'($urandom));
    in_valid = 1'b0;
    repeat (20) step();

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    repeat (15) begin
      in_data = NI'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    check("bp_accepts", acc, FIFO_DEPTH);
    @(negedge clk);
    check("bp_stalled", in_ready, 0);
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("bp_credit_back", in_ready, 1);
    out_ready = 1'b1;
    repeat (15) step();

    // mid-flight reset
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      in_data = NI'($urandom);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_inflight", inflight, 3);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_inflight", inflight, 0);
    end
    step();

    // exhaustive c17
    out_ready = 1'b1;
    for (int v = 0; v < 32; v++) send(NI'(v));
    in_valid = 1'b0;
    repeat (20) step();

    // random traffic
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = NI'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    check("drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
